qpu_tiq_timer: RTL and testbench

//  Timing-instruction queue and countdown timer, directly downstream of QPU_exu.

---
 rtl/qpu_tiq_timer.sv | 135 +++++++++++++
 tb/tb_qpu_tiq_timer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_tiq_timer.sv
// Timing-instruction queue feeding an in-order countdown timer, plus the free-running QPU timestamp.
// Each buffered interval is counted down and then presented as a timepoint valid/ready handshake.
module qpu_tiq_timer #(
    parameter int unsigned TIME_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tiq_flush,
    input  logic                  tiq_wbck_ena,
    output logic                  tiq_wbck_ready,
    input  logic [TIME_WIDTH-1:0] tiq_wbck_data,
    input  logic                  tmr_ena,
    output logic                  tmr_fire_valid,
    input  logic                  tmr_fire_ready,
    output logic [CNT_W-1:0]      tiq_count,
    output logic                  tiq_empty,
    output logic [TIME_WIDTH-1:0] tmr_clk
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [TIME_WIDTH-1:0] cnt;
    logic [TIME_WIDTH-1:0] cnt_nxt;
    logic [TIME_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [TIME_WIDTH-1:0] head;
    logic                  push;
    logic                  pop;
    logic                  can_pop;

    // Flow control decodes straight from registered occupancy, so a same-cycle pop never frees a slot.
    assign tiq_wbck_ready = (tiq_count != CNT_W'(DEPTH));
    assign tiq_empty      = (tiq_count == '0);
    assign tmr_fire_valid = (state == FIRE);
    assign head           = mem[rd_ptr];
    assign push           = tiq_wbck_ena && tiq_wbck_ready && !tiq_flush;
    assign can_pop        = tmr_ena && !tiq_empty;

    // Next-state: pop is only legal from IDLE or on a FIRE handshake; flush overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                pop = can_pop;
            end
            COUNT: begin
                if (tmr_ena) begin
                    if (cnt == '0) begin
                        state_nxt = FIRE;
                    end else begin
                        cnt_nxt = cnt - TIME_WIDTH'(1);
                    end
                end
            end
            FIRE: begin
                if (tmr_fire_ready) begin
                    state_nxt = IDLE;
                    pop       = can_pop;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Loading D-1 gives a fire exactly D+1 cycles after the pop.
        if (pop) begin
            if (head == '0) begin
                state_nxt = FIRE;
            end else begin
                state_nxt = COUNT;
                cnt_nxt   = head - TIME_WIDTH'(1);
            end
        end
        if (tiq_flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pop       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tiq_count <= '0;
            tmr_clk   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (tmr_ena) begin
                tmr_clk <= tmr_clk + TIME_WIDTH'(1);
            end
            if (tiq_flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                tiq_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   tiq_count <= tiq_count + CNT_W'(1);
                    2'b01:   tiq_count <= tiq_count - CNT_W'(1);
                    default: tiq_count <= tiq_count;
                endcase
            end
        end
    end

    // Payload storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tiq_wbck_data;
        end
    end

endmodule

// File: tb/tb_qpu_tiq_timer.sv
// Self-checking bench for qpu_tiq_timer: fill table, scoreboard of expected fire cycles, corner sequences.
// A narrow second instance exercises timestamp wrap-around.
module tb_qpu_tiq_timer;

    localparam int unsigned TW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          tiq_flush;
    logic          tiq_wbck_ena;
    logic          tiq_wbck_ready;
    logic [TW-1:0] tiq_wbck_data;
    logic          tmr_ena;
    logic          tmr_fire_valid;
    logic          tmr_fire_ready;
    logic [2:0]    tiq_count;
    logic          tiq_empty;
    logic [TW-1:0] tmr_clk;

    logic          w_ena;
    logic          w_ready;
    logic          w_valid;
    logic [2:0]    w_count;
    logic          w_empty;
    logic [3:0]    w_clk;

    always #5 clk = ~clk;

    qpu_tiq_timer #(.TIME_WIDTH(TW), .DEPTH(4), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .tiq_flush      (tiq_flush),
        .tiq_wbck_ena   (tiq_wbck_ena),
        .tiq_wbck_ready (tiq_wbck_ready),
        .tiq_wbck_data  (tiq_wbck_data),
        .tmr_ena        (tmr_ena),
        .tmr_fire_valid (tmr_fire_valid),
        .tmr_fire_ready (tmr_fire_ready),
        .tiq_count      (tiq_count),
        .tiq_empty      (tiq_empty),
        .tmr_clk        (tmr_clk)
    );

    qpu_tiq_timer #(.TIME_WIDTH(4), .DEPTH(4), .CNT_W(3)) dut_w (
        .clk            (clk),
        .rst            (rst),
        .tiq_flush      (1'b0),
        .tiq_wbck_ena   (1'b0),
        .tiq_wbck_ready (w_ready),
        .tiq_wbck_data  (4'd0),
        .tmr_ena        (w_ena),
        .tmr_fire_valid (w_valid),
        .tmr_fire_ready (1'b1),
        .tiq_count      (w_count),
        .tiq_empty      (w_empty),
        .tmr_clk        (w_clk)
    );

    typedef struct {
        logic          ena;
        logic [TW-1:0] data;
        int            exp_count;
        logic          exp_ready;
    } vec_t;

    vec_t     vecs [6];
    int       checks    = 0;
    int       failures  = 0;
    int       cyc       = 0;
    int       last_fire = 0;
    int       exp_q [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // Expected fire cycle: pop at the later of availability and the previous handshake, fire D+1 later.
    task automatic expect_entry(input int avail, input int d);
        int pop_c;
        pop_c = (avail > last_fire) ? avail : last_fire;
        last_fire = pop_c + 1 + d;
        exp_q.push_back(last_fire);
    endtask

    // Advance one cycle; every handshake seen at the falling edge is matched against the scoreboard.
    task automatic tick();
        int e;
        @(negedge clk);
        if (!rst && tmr_fire_valid && tmr_fire_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL fire_unexpected cycle=%0d got=handshake expected=none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e != cyc) begin
                    failures++;
                    $display("FAIL fire_cycle got=%0d expected=%0d", cyc, e);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int d);
        tiq_wbck_ena  = 1'b1;
        tiq_wbck_data = TW'(d);
        tick();
        tiq_wbck_ena  = 1'b0;
        tiq_wbck_data = '0;
    endtask

    initial begin
        int p;
        int e0;
        logic [TW-1:0] ts0;

        vecs[0] = '{1'b1, 32'd2, 1, 1'b1};
        vecs[1] = '{1'b1, 32'd0, 2, 1'b1};
        vecs[2] = '{1'b1, 32'd1, 3, 1'b1};
        vecs[3] = '{1'b1, 32'd3, 4, 1'b0};
        vecs[4] = '{1'b1, 32'd7, 4, 1'b0};
        vecs[5] = '{1'b0, 32'd0, 4, 1'b0};

        rst = 1'b1; tiq_flush = 1'b0; tiq_wbck_ena = 1'b0; tiq_wbck_data = '0;
        tmr_ena = 1'b0; tmr_fire_ready = 1'b1; w_ena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(tiq_wbck_ready), 64'(1));
        chk("rst_empty", 64'(tiq_empty), 64'(1));
        chk("rst_count", 64'(tiq_count), 64'(0));
        chk("rst_valid", 64'(tmr_fire_valid), 64'(0));
        chk("rst_tmr_clk", 64'(tmr_clk), 64'(0));
        rst = 1'b0;
        tick();

        // D=0: single-cycle fire right after the pop.
        tmr_ena = 1'b1;
        p = cyc;
        expect_entry(p + 1, 0);
        push(0);
        tick();
        tick();
        chk("d0_valid_one_cycle", 64'(tmr_fire_valid), 64'(0));
        chk("d0_empty", 64'(tiq_empty), 64'(1));

        // D=5 then D=2 back-to-back.
        p = cyc;
        expect_entry(p + 1, 5);
        push(5);
        expect_entry(p + 2, 2);
        push(2);
        repeat (12) tick();
        chk("b2b_count", 64'(tiq_count), 64'(0));
        chk("b2b_scoreboard", 64'(exp_q.size()), 64'(0));

        // Fill to full with timing frozen; the fifth push must be dropped.
        tmr_ena = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tiq_wbck_ena  = vecs[i].ena;
            tiq_wbck_data = vecs[i].data;
            tick();
            chk("fill_count", 64'(tiq_count), 64'(vecs[i].exp_count));
            chk("fill_ready", 64'(tiq_wbck_ready), 64'(vecs[i].exp_ready));
            chk("fill_empty", 64'(tiq_empty), 64'(vecs[i].exp_count == 0));
        end
        tiq_wbck_ena = 1'b0;
        tiq_wbck_data = '0;
        tmr_ena = 1'b1;
        e0 = cyc;
        expect_entry(e0, 2);
        expect_entry(e0, 0);
        expect_entry(e0, 1);
        expect_entry(e0, 3);
        tick();
        chk("pop_frees_count", 64'(tiq_count), 64'(3));
        chk("pop_frees_ready", 64'(tiq_wbck_ready), 64'(1));
        repeat (14) tick();
        chk("drain_empty", 64'(tiq_empty), 64'(1));

        // D=3 with tmr_ena low for 4 cycles mid-count.
        p = cyc;
        push(3);
        tick();
        tmr_ena = 1'b0;
        ts0 = tmr_clk;
        repeat (4) tick();
        tmr_ena = 1'b1;
        chk("freeze_tmr_clk", 64'(tmr_clk), 64'(ts0));
        chk("freeze_no_fire", 64'(tmr_fire_valid), 64'(0));
        exp_q.push_back(p + 9);
        last_fire = p + 9;
        tick();
        chk("resume_tmr_clk", 64'(tmr_clk), 64'(ts0 + TW'(1)));
        repeat (6) tick();

        // Stall in FIRE for 10 cycles with a second entry waiting.
        tmr_fire_ready = 1'b0;
        p = cyc;
        push(1);
        push(0);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(tmr_fire_valid), 64'(1));
            chk("stall_count", 64'(tiq_count), 64'(1));
            tick();
        end
        tmr_fire_ready = 1'b1;
        exp_q.push_back(p + 13);
        last_fire = p + 13;
        expect_entry(p + 2, 0);
        repeat (4) tick();
        chk("stall_drain_count", 64'(tiq_count), 64'(0));

        // Flush with three queued, a same-cycle push and the timer mid-count.
        push(20);
        push(1);
        push(1);
        push(1);
        chk("preflush_count", 64'(tiq_count), 64'(3));
        tiq_flush = 1'b1;
        tiq_wbck_ena = 1'b1;
        tiq_wbck_data = TW'(1);
        ts0 = tmr_clk;
        tick();
        tiq_flush = 1'b0;
        tiq_wbck_ena = 1'b0;
        chk("flush_count", 64'(tiq_count), 64'(0));
        chk("flush_empty", 64'(tiq_empty), 64'(1));
        chk("flush_ready", 64'(tiq_wbck_ready), 64'(1));
        chk("flush_valid", 64'(tmr_fire_valid), 64'(0));
        chk("flush_tmr_clk", 64'(tmr_clk), 64'(ts0 + TW'(1)));
        repeat (30) tick();
        last_fire = 0;
        expect_entry(cyc + 1, 0);
        push(0);
        repeat (4) tick();

        // Asynchronous reset in the middle of a countdown.
        push(10);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(tmr_fire_valid), 64'(0));
        chk("arst_count", 64'(tiq_count), 64'(0));
        chk("arst_empty", 64'(tiq_empty), 64'(1));
        chk("arst_tmr_clk", 64'(tmr_clk), 64'(0));
        tick();
        rst = 1'b0;
        last_fire = 0;
        repeat (15) tick();

        // Narrow timestamp wraps from all-ones to zero.
        chk("wrap_start", 64'(w_clk), 64'(0));
        w_ena = 1'b1;
        repeat (15) tick();
        chk("wrap_max", 64'(w_clk), 64'(15));
        tick();
        chk("wrap_zero", 64'(w_clk), 64'(0));
        w_ena = 1'b0;

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
